// File: rtl/cpu_define.sv
// rtl/cpu_define.sv - core-wide widths, fetch reset vector and instruction queue entry type
package cpu_define;

  localparam int ADDR_WIDTH = 32;
  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] IFU_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - parameterized synchronous FIFO with single-cycle flush
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop & !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push   = push & (!full | do_pop);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO in one edge
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit with credit-based queue and redirect; IFU_FETCH_PERF_EN adds perf_bubble_cnt
module ifu_fetch
  import cpu_define::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC   = IFU_RESET_PC,
  parameter int                  IBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_addr_vld,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_rsp_data_vld,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
  input  logic                  alu_branch_taken,
  input  logic [PC_WIDTH-1:0]   alu_branch_pc,
  input  logic                  dec_rdy,
  output logic                  ifu_vld,
  output logic [PC_WIDTH-1:0]   ifu_pc,
  output logic [INST_WIDTH-1:0] ifu_inst
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  if (DATA_WIDTH != INST_WIDTH) begin : g_width_chk
    $error("ifu_fetch: DATA_WIDTH must equal INST_WIDTH");
  end
  if (IBUF_DEPTH < 2 || (IBUF_DEPTH & (IBUF_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("ifu_fetch: IBUF_DEPTH must be a power of two >= 2");
  end

  logic                rst_n_q;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]       drop_cnt;
  logic [CW-1:0]       occ;
  logic [CW-1:0]       inflight;
  logic [CW+1:0]       credit_used;
  logic                rsp_keep;
  logic                pop;
  logic                q_empty;
  logic [PC_WIDTH-1:0] tag_pc;
  ifu_entry_t          q_head;
  ifu_entry_t          q_push_entry;

  // Every slot is reserved at issue time: buffered + in flight + still-to-drop
  assign credit_used      = (CW+2)'(occ) + (CW+2)'(inflight) + (CW+2)'(drop_cnt);
  assign ifu_req_addr_vld = rst_n_q & !alu_branch_taken & (credit_used < (CW+2)'(IBUF_DEPTH));
  assign ifu_req_addr     = ADDR_WIDTH'(fetch_pc);

  // Stale responses are swallowed first; a response in the redirect cycle is always stale
  assign rsp_keep     = ifu_rsp_data_vld & (drop_cnt == '0) & !alu_branch_taken;
  assign q_push_entry = '{pc: tag_pc, inst: ifu_rsp_data};

  assign q_empty  = (occ == '0);
  assign ifu_vld  = !q_empty & !alu_branch_taken;
  assign pop      = ifu_vld & dec_rdy;
  assign ifu_pc   = q_empty ? '0 : q_head.pc;
  assign ifu_inst = q_empty ? '0 : q_head.inst;

  // Address tag for each outstanding request; its occupancy is the in-flight count
  ifu_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (IBUF_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (alu_branch_taken),
    .push      (ifu_req_addr_vld),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head_data (tag_pc),
    .count     (inflight)
  );

  // Instruction queue presented to decode
  ifu_fifo #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (IBUF_DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (alu_branch_taken),
    .push      (rsp_keep),
    .push_data (q_push_entry),
    .pop       (pop),
    .head_data (q_head),
    .count     (occ)
  );

  // Fetch PC, stale-response counter and the one-cycle request holdoff after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q  <= 1'b0;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      rst_n_q <= 1'b1;
      if (alu_branch_taken) begin
        fetch_pc <= alu_branch_pc & ~PC_WIDTH'(3);
        drop_cnt <= drop_cnt + inflight - CW'(ifu_rsp_data_vld);
      end else begin
        if (ifu_req_addr_vld) fetch_pc <= fetch_pc + PC_WIDTH'(4);
        if (ifu_rsp_data_vld && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

`ifdef IFU_FETCH_PERF_EN
  // Counts cycles where fetch is live but decode has nothing to take
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
    end else if (rst_n_q && !ifu_vld) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch; IFU_FETCH_PERF_EN adds the perf counter checks
module tb_ifu_fetch;
  import cpu_define::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br;
  logic [31:0] br_pc;
  logic        dec_rdy;
  logic        rsp_vld = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        vld;
  logic [31:0] pc;
  logic [31:0] inst;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf;
  logic        p_req;
  logic [31:0] p_addr;
  logic        p_vld;
  logic [31:0] p_pc;
  logic [31:0] p_inst;
  logic [31:0] p_perf;
  logic        p_rsp_vld = 1'b0;
  logic [31:0] p_rsp_data = '0;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0), .IBUF_DEPTH(D)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_addr_vld (req_vld),
    .ifu_req_addr     (req_addr),
    .ifu_rsp_data_vld (rsp_vld),
    .ifu_rsp_data     (rsp_data),
    .alu_branch_taken (br),
    .alu_branch_pc    (br_pc),
    .dec_rdy          (dec_rdy),
    .ifu_vld          (vld),
    .ifu_pc           (pc),
    .ifu_inst         (inst)
`ifdef IFU_FETCH_PERF_EN
    ,
    .perf_bubble_cnt  (perf)
`endif
  );

`ifdef IFU_FETCH_PERF_EN
  ifu_fetch #(.RESET_PC(32'h0), .IBUF_DEPTH(2)) u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_addr_vld (p_req),
    .ifu_req_addr     (p_addr),
    .ifu_rsp_data_vld (p_rsp_vld),
    .ifu_rsp_data     (p_rsp_data),
    .alu_branch_taken (1'b0),
    .alu_branch_pc    (32'h0),
    .dec_rdy          (1'b1),
    .ifu_vld          (p_vld),
    .ifu_pc           (p_pc),
    .ifu_inst         (p_inst),
    .perf_bubble_cnt  (p_perf)
  );
`endif

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out waiting for DUT", name);
  endtask

  // Memory: in-order responses, each due a set number of cycles after acceptance
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] m_addr[$];
  int          m_due[$];
  logic [31:0] pm_addr[$];
  int          pm_due[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (m_due.size() > 0 && m_due[0] <= cyc) begin
      rsp_vld  = 1'b1;
      rsp_data = mem_word(m_addr.pop_front());
      void'(m_due.pop_front());
    end else begin
      rsp_vld  = 1'b0;
      rsp_data = 32'hDEAD_BEEF;
    end
`ifdef IFU_FETCH_PERF_EN
    if (pm_due.size() > 0 && pm_due[0] <= cyc) begin
      p_rsp_vld  = 1'b1;
      p_rsp_data = mem_word(pm_addr.pop_front());
      void'(pm_due.pop_front());
    end else begin
      p_rsp_vld  = 1'b0;
      p_rsp_data = 32'hDEAD_BEEF;
    end
`endif
  end

  // Reference model: queue of buffered pcs, queue of outstanding request pcs
  logic [31:0] mq[$];
  logic [31:0] mt[$];
  int          m_drop = 0;
  logic [31:0] m_fpc = 32'h0;
  bit          m_rstq = 0;
  bit          m_live = 0;
  logic [31:0] m_perf = 0;
  int          p_occ = 0;
  int          p_inf = 0;
  logic [31:0] p_cnt = 0;
  logic [31:0] p_epc = 0;

  logic [31:0] req_log_addr[$];
  int          req_log_cyc[$];
  logic [31:0] deliv[$];
  int          first_req_cyc = -1;
  int          first_vld_cyc = -1;
  int          strobe_cyc = 0;
  logic        strobe_vld = 1'b1;

  // Compare on the falling edge, then advance the model to the next rising edge
  always @(negedge clk) begin
    bit e_req;
    bit e_vld;
    bit e_preq;
    bit e_pvld;
    e_req  = m_rstq && !br && (mq.size() + mt.size() + m_drop < D);
    e_vld  = (mq.size() > 0) && !br;
    e_preq = m_rstq && (p_occ + p_inf < 2);
    e_pvld = p_occ > 0;
    if (m_live) begin
      chk("req_vld", req_vld, e_req);
      if (e_req) chk("req_addr", req_addr, m_fpc);
      chk("ifu_vld", vld, e_vld);
      if (e_vld) begin
        chk("ifu_pc", pc, mq[0]);
        chk("ifu_inst", inst, mem_word(mq[0]));
      end
      if (!m_rstq) begin
        chk("reset_pc", pc, 32'h0);
        chk("reset_inst", inst, 32'h0);
      end
`ifdef IFU_FETCH_PERF_EN
      chk("perf_cnt", perf, m_perf);
      chk("p_req_vld", p_req, e_preq);
      chk("p_ifu_vld", p_vld, e_pvld);
      if (e_pvld) chk("p_ifu_pc", p_pc, p_epc);
      chk("p_perf_cnt", p_perf, p_cnt);
      if (p_req) begin
        pm_addr.push_back(p_addr);
        pm_due.push_back(cyc + 3);
      end
`endif
    end
    if (req_vld === 1'b1) begin
      m_addr.push_back(req_addr);
      m_due.push_back(cyc + lat);
      req_log_addr.push_back(req_addr);
      req_log_cyc.push_back(cyc);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (vld === 1'b1 && dec_rdy) deliv.push_back(pc);
    if (br && m_live) begin
      strobe_vld = vld;
      strobe_cyc = cyc;
    end

    if (!rst_n) begin
      p_occ = 0; p_inf = 0; p_cnt = 0; p_epc = 0;
    end else if (m_live) begin
      if (m_rstq && !e_pvld) p_cnt++;
      if (e_pvld) begin p_occ--; p_epc += 4; end
`ifdef IFU_FETCH_PERF_EN
      if (p_rsp_vld) begin p_occ++; p_inf--; end
`endif
      if (e_preq) p_inf++;
    end

    if (!rst_n) begin
      mq.delete(); mt.delete();
      m_drop = 0; m_fpc = 32'h0; m_rstq = 0; m_perf = 0; m_live = 1;
    end else if (m_live) begin
      if (m_rstq && !e_vld) m_perf++;
      m_rstq = 1;
      if (br) begin
        m_drop = m_drop + mt.size() - (rsp_vld ? 1 : 0);
        mt.delete(); mq.delete();
        m_fpc = {br_pc[31:2], 2'b00};
      end else begin
        if (e_vld && dec_rdy) void'(mq.pop_front());
        if (rsp_vld) begin
          if (m_drop > 0) m_drop--;
          else if (mt.size() > 0) mq.push_back(mt.pop_front());
        end
        if (e_req) begin
          mt.push_back(m_fpc);
          m_fpc += 32'd4;
        end
      end
    end
  end

  // Directed scenarios with literal expectations
  initial begin
    int  n0;
    int  r0;
    int  rel0;
    bit  found;
    rst_n = 0; br = 0; br_pc = '0; dec_rdy = 0; lat = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rel0 = cyc;

    repeat (10) @(posedge clk);
    #1;
    chk("reqs_while_stalled", req_log_addr.size(), 4);
    chk("first_req_cycle", first_req_cyc - rel0, 1);
    chk("first_vld_latency", first_vld_cyc - first_req_cyc, 2);
    r0 = req_log_addr.size();
    dec_rdy = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (deliv.size() >= 5 && req_log_addr.size() > r0) found = 1;
    end
    if (!found) timeout("drain_after_stall");
    else begin
      chk("drain_pc0", deliv[0], 32'h0);
      chk("drain_pc1", deliv[1], 32'h4);
      chk("drain_pc2", deliv[2], 32'h8);
      chk("drain_pc3", deliv[3], 32'hC);
      chk("resume_addr", req_log_addr[r0], 32'h10);
    end

    repeat (10) @(posedge clk);
    #1 n0 = deliv.size();
    repeat (8) @(posedge clk);
    #1 chk("throughput", deliv.size() - n0, 8);

    lat = 2;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (mt.size() == 2) found = 1;
    end
    if (!found) timeout("two_in_flight");
    n0 = deliv.size();
    br = 1; br_pc = 32'h100;
    @(posedge clk); #1 br = 0;
    chk("strobe_vld", strobe_vld, 1'b0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (deliv.size() > n0) found = 1;
    end
    if (!found) timeout("redir_100");
    else chk("redir_first_pc", deliv[n0], 32'h100);

    repeat (6) @(posedge clk);
    #2 r0 = req_log_addr.size();
    br = 1; br_pc = 32'h203;
    @(posedge clk); #1 br = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (req_log_addr.size() > r0) found = 1;
    end
    if (!found) timeout("redir_203");
    else begin
      chk("redir_align", req_log_addr[r0], 32'h200);
      chk("redir_req_cycle", req_log_cyc[r0] - strobe_cyc, 1);
    end

    repeat (8) @(posedge clk);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (rsp_vld && vld && dec_rdy) found = 1;
    end
    if (!found) timeout("coincident");
    n0 = deliv.size();
    br = 1; br_pc = 32'h400;
    @(posedge clk); #1 br = 0;
    chk("no_pop_on_redirect", deliv.size() - n0, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (deliv.size() > n0) found = 1;
    end
    if (!found) timeout("redir_400");
    else chk("coinc_first_pc", deliv[n0], 32'h400);

    repeat (5) @(posedge clk);
    #2 r0 = req_log_addr.size();
    n0 = deliv.size();
    br = 1; br_pc = 32'h500;
    @(posedge clk); #1 br_pc = 32'h600;
    @(posedge clk); #1 br = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (deliv.size() > n0 && req_log_addr.size() > r0) found = 1;
    end
    if (!found) timeout("b2b_redirect");
    else begin
      chk("b2b_req_addr", req_log_addr[r0], 32'h600);
      chk("b2b_first_pc", deliv[n0], 32'h600);
    end

    repeat (20) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
